linebuffer_mn: RTL and testbench

Parametrised multi-entry fetch line buffer that sits between the fetch stage and the instruction cache/memory path. It holds ENTRIES fully-associative cache lines and answers same-cycle PC lookups with a hit flag and the selected word. On a miss it issues one outstanding line request through a ready/valid handshake. Replacement is true LRU, and a flush squashes the fill already in flight.

---
 rtl/linebuffer_mn_pkg.sv | 26 ++
 rtl/linebuffer_mn_if.sv | 32 +++
 rtl/linebuffer_mn_lru.sv | 31 +++
 rtl/linebuffer_mn.sv | 143 ++++++++++++++
 tb/tb_linebuffer_mn.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/linebuffer_mn_pkg.sv
// Shared types, default sizes and address-split helpers for the fetch line buffer.
package linebuffer_pkg;

  typedef enum logic [1:0] {
    LB_IDLE = 2'd0,
    LB_REQ  = 2'd1,
    LB_WAIT = 2'd2
  } lb_state_t;

  localparam int unsigned LB_ENTRIES    = 4;
  localparam int unsigned LB_LINE_WORDS = 8;
  localparam int unsigned LB_WORD_W     = 32;
  localparam int unsigned LB_ADDR_W     = 32;

  // Bits below the tag: byte offset within a line.
  function automatic int unsigned lb_off_bits(input int unsigned line_words,
                                              input int unsigned word_w);
    return $clog2(line_words * word_w / 8);
  endfunction

  // Bits below the word index: byte offset within a word.
  function automatic int unsigned lb_byte_bits(input int unsigned word_w);
    return $clog2(word_w / 8);
  endfunction

endpackage

// File: rtl/linebuffer_mn_if.sv
// Lookup, miss-request and fill bus between fetch, the line buffer and memory.
// Handshake: a miss request transfers on a cycle where miss_valid and miss_ready are both 1;
// miss_valid/miss_addr hold steady until that transfer or a withdrawal by a matching fill.
interface linebuffer_mn_if
  import linebuffer_pkg::*;
#(
  parameter int unsigned ADDR_W     = LB_ADDR_W,
  parameter int unsigned WORD_W     = LB_WORD_W,
  parameter int unsigned LINE_WORDS = LB_LINE_WORDS
) ();
  logic                         req_valid;
  logic [ADDR_W-1:0]            req_pc;
  logic                         hit;
  logic [WORD_W-1:0]            word;
  logic                         miss_valid;
  logic [ADDR_W-1:0]            miss_addr;
  logic                         miss_ready;
  logic                         fill_valid;
  logic [ADDR_W-1:0]            fill_addr;
  logic [LINE_WORDS*WORD_W-1:0] fill_data;
  logic                         invalidate;

  modport master (
    output req_valid, req_pc, miss_ready, fill_valid, fill_addr, fill_data, invalidate,
    input  hit, word, miss_valid, miss_addr
  );

  modport slave (
    input  req_valid, req_pc, miss_ready, fill_valid, fill_addr, fill_data, invalidate,
    output hit, word, miss_valid, miss_addr
  );
endinterface

// File: rtl/linebuffer_mn_lru.sv
// True-LRU age tracker: ages are a permutation, the accessed entry becomes youngest.
module lb_lru #(
  parameter  int unsigned ENTRIES = 4,
  localparam int unsigned EW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_en_i,
  input  logic [EW-1:0] acc_idx_i,
  output logic [EW-1:0] lru_idx_o
);
  logic [EW-1:0] age_q [ENTRIES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= EW'(i);
    end else if (acc_en_i) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if (EW'(j) == acc_idx_i)                 age_q[j] <= '0;
        else if (age_q[j] < age_q[acc_idx_i])    age_q[j] <= age_q[j] + 1'b1;
      end
    end
  end

  always_comb begin
    lru_idx_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (age_q[i] == {EW{1'b1}}) lru_idx_o = EW'(i);
    end
  end
endmodule

// File: rtl/linebuffer_mn.sv
// Fully-associative fetch line buffer with combinational lookup, one outstanding
// line miss request, true-LRU replacement and flush-time squash of an in-flight fill.
module linebuffer_mn
  import linebuffer_pkg::*;
#(
  parameter int unsigned ENTRIES    = LB_ENTRIES,
  parameter int unsigned LINE_WORDS = LB_LINE_WORDS,
  parameter int unsigned WORD_W     = LB_WORD_W,
  parameter int unsigned ADDR_W     = LB_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  linebuffer_mn_if.slave   bus,
  output lb_state_t        dbg_state_o
);
  localparam int unsigned OFF    = lb_off_bits(LINE_WORDS, WORD_W);
  localparam int unsigned BYTE_B = lb_byte_bits(WORD_W);
  localparam int unsigned IDX_W  = OFF - BYTE_B;
  localparam int unsigned TAG_W  = ADDR_W - OFF;
  localparam int unsigned EW     = $clog2(ENTRIES);
  localparam int unsigned LINE_W = LINE_WORDS * WORD_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [LINE_W-1:0]  data_q [ENTRIES];
  lb_state_t          state_q;
  logic               squash_q;
  logic               miss_valid_q;
  logic [ADDR_W-1:0]  miss_addr_q;

  logic [TAG_W-1:0]   req_tag, fill_tag, miss_tag;
  logic [IDX_W-1:0]   word_idx;
  logic [ENTRIES-1:0] hit_vec, fill_match;
  logic [EW-1:0]      hit_idx, match_idx, free_idx, lru_idx, fill_idx, acc_idx;
  logic               has_free, hit, fill_accept, acc_en;
  logic               unused_bits;

  assign req_tag     = bus.req_pc[ADDR_W-1:OFF];
  assign fill_tag    = bus.fill_addr[ADDR_W-1:OFF];
  assign miss_tag    = miss_addr_q[ADDR_W-1:OFF];
  assign word_idx    = bus.req_pc[OFF-1:BYTE_B];
  assign unused_bits = ^{bus.fill_addr[OFF-1:0], bus.req_pc[BYTE_B-1:0]};

  // Descending scans so the lowest matching / free index wins.
  always_comb begin
    hit_vec    = '0;
    fill_match = '0;
    hit_idx    = '0;
    match_idx  = '0;
    free_idx   = '0;
    has_free   = 1'b0;
    for (int e = 0; e < ENTRIES; e++) begin
      hit_vec[e]    = valid_q[e] && (tag_q[e] == req_tag);
      fill_match[e] = valid_q[e] && (tag_q[e] == fill_tag);
    end
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (hit_vec[e])    hit_idx   = EW'(e);
      if (fill_match[e]) match_idx = EW'(e);
      if (!valid_q[e]) begin
        free_idx = EW'(e);
        has_free = 1'b1;
      end
    end
  end

  assign hit         = bus.req_valid && (|hit_vec);
  assign fill_accept = bus.fill_valid && !bus.invalidate && !squash_q;
  assign fill_idx    = (|fill_match) ? match_idx : (has_free ? free_idx : lru_idx);
  assign acc_en      = fill_accept || hit;
  assign acc_idx     = fill_accept ? fill_idx : hit_idx;

  assign bus.hit        = hit;
  assign bus.word       = data_q[hit_idx][word_idx*WORD_W +: WORD_W];
  assign bus.miss_valid = miss_valid_q;
  assign bus.miss_addr  = miss_addr_q;
  assign dbg_state_o    = state_q;

  lb_lru #(.ENTRIES(ENTRIES)) u_lru (
    .clk       (clk),
    .rst       (rst),
    .acc_en_i  (acc_en),
    .acc_idx_i (acc_idx),
    .lru_idx_o (lru_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int e = 0; e < ENTRIES; e++) begin
        tag_q[e]  <= '0;
        data_q[e] <= '0;
      end
    end else if (bus.invalidate) begin
      valid_q <= '0;
    end else if (fill_accept) begin
      valid_q[fill_idx] <= 1'b1;
      tag_q[fill_idx]   <= fill_tag;
      data_q[fill_idx]  <= bus.fill_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LB_IDLE;
      squash_q     <= 1'b0;
      miss_valid_q <= 1'b0;
      miss_addr_q  <= '0;
    end else begin
      if (bus.fill_valid && squash_q && !bus.invalidate) squash_q <= 1'b0;
      case (state_q)
        LB_IDLE: begin
          if (bus.req_valid && !hit && !bus.invalidate && !(fill_accept && fill_tag == req_tag)) begin
            state_q      <= LB_REQ;
            miss_valid_q <= 1'b1;
            miss_addr_q  <= {req_tag, {OFF{1'b0}}};
          end
        end
        LB_REQ: begin
          // A fill of the requested line makes the request pointless, so it is withdrawn.
          if (bus.invalidate || (fill_accept && fill_tag == miss_tag)) begin
            state_q      <= LB_IDLE;
            miss_valid_q <= 1'b0;
          end else if (bus.miss_ready) begin
            state_q      <= LB_WAIT;
            miss_valid_q <= 1'b0;
          end
        end
        LB_WAIT: begin
          if (bus.invalidate) begin
            state_q  <= LB_IDLE;
            squash_q <= 1'b1;
          end else if (fill_accept) begin
            state_q <= LB_IDLE;
          end
        end
        default: begin
          state_q      <= LB_IDLE;
          miss_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_linebuffer_mn.sv
// Directed bench for linebuffer_mn: lookups, LRU eviction, refill, miss handshake, squash, reset.
module tb_linebuffer_mn;
  import linebuffer_pkg::*;

  localparam int unsigned ENTRIES    = 4;
  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = 32;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  lb_state_t dbg_state;
  int        total = 0;
  int        bad   = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] model_base [int];

  linebuffer_mn_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) bus ();

  linebuffer_mn #(
    .ENTRIES(ENTRIES), .LINE_WORDS(LINE_WORDS), .WORD_W(WORD_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic lookup(input logic [ADDR_W-1:0] pc, input logic exp_hit);
    logic [WORD_W-1:0] w;
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    if (exp_hit) exp_q.push_back(model_base[int'(pc >> 5)] + WORD_W'((pc >> 2) & 7));
    #1;
    check($sformatf("hit@%0h", pc), 64'(bus.hit), 64'(exp_hit));
    if (exp_hit) begin
      w = exp_q.pop_front();
      check($sformatf("word@%0h", pc), 64'(bus.word), 64'(w));
    end
  endtask

  task automatic drive_fill(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] base);
    bus.fill_valid = 1'b1;
    bus.fill_addr  = a;
    for (int i = 0; i < LINE_WORDS; i++) bus.fill_data[i*WORD_W +: WORD_W] = base + WORD_W'(i);
    model_base[int'(a >> 5)] = base;
  endtask

  task automatic fill(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] base);
    drive_fill(a, base);
    tick();
    bus.fill_valid = 1'b0;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_pc     = '0;
    bus.miss_ready = 1'b0;
    bus.fill_valid = 1'b0;
    bus.fill_addr  = '0;
    bus.fill_data  = '0;
    bus.invalidate = 1'b0;
    #2;
    check("rst_miss_valid", 64'(bus.miss_valid), 64'(0));
    check("rst_miss_addr", 64'(bus.miss_addr), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(LB_IDLE));
    tick();
    tick();
    rst = 1'b1;

    // cold miss and request handshake
    lookup(32'h10, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    check("cold_miss_valid", 64'(bus.miss_valid), 64'(1));
    check("cold_miss_addr", 64'(bus.miss_addr), 64'(32'h0));
    check("cold_state_req", 64'(dbg_state), 64'(LB_REQ));
    tick();
    check("hold_miss_valid", 64'(bus.miss_valid), 64'(1));
    check("hold_miss_addr", 64'(bus.miss_addr), 64'(32'h0));
    bus.miss_ready = 1'b1;
    tick();
    bus.miss_ready = 1'b0;
    check("state_wait", 64'(dbg_state), 64'(LB_WAIT));
    check("wait_miss_valid", 64'(bus.miss_valid), 64'(0));

    // fill line 0, no same-cycle bypass, then every word hits
    drive_fill(32'h000, 32'hA5A5_0000);
    lookup(32'h04, 1'b0);
    bus.req_valid = 1'b0;
    tick();
    bus.fill_valid = 1'b0;
    check("fill_state_idle", 64'(dbg_state), 64'(LB_IDLE));
    for (int i = 0; i < 8; i++) lookup(32'(i * 4), 1'b1);
    bus.req_valid = 1'b0;

    // LRU eviction: 0x020 is least recently used when 0x080 arrives
    fill(32'h020, 32'hB002_0000);
    fill(32'h040, 32'hB004_0000);
    fill(32'h060, 32'hB006_0000);
    lookup(32'h000, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    fill(32'h080, 32'hB008_0000);
    lookup(32'h020, 1'b0);
    lookup(32'h000, 1'b1);
    lookup(32'h044, 1'b1);
    lookup(32'h068, 1'b1);
    lookup(32'h09C, 1'b1);
    bus.req_valid = 1'b0;

    // refill in place: new data, nothing evicted
    fill(32'h040, 32'hC004_0000);
    lookup(32'h040, 1'b1);
    lookup(32'h05C, 1'b1);
    lookup(32'h000, 1'b1);
    lookup(32'h060, 1'b1);
    lookup(32'h080, 1'b1);
    lookup(32'h020, 1'b0);

    // request withdrawn by a fill of the requested line; 0x060 is then LRU victim
    lookup(32'h024, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    check("wd_miss_valid", 64'(bus.miss_valid), 64'(1));
    check("wd_miss_addr", 64'(bus.miss_addr), 64'(32'h20));
    fill(32'h020, 32'hD002_0000);
    check("wd_state_idle", 64'(dbg_state), 64'(LB_IDLE));
    check("wd_miss_dropped", 64'(bus.miss_valid), 64'(0));
    lookup(32'h020, 1'b1);
    lookup(32'h060, 1'b0);
    lookup(32'h000, 1'b1);
    lookup(32'h040, 1'b1);
    lookup(32'h080, 1'b1);
    bus.req_valid = 1'b0;

    // invalidate in WAIT squashes the in-flight fill
    lookup(32'h100, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    check("sq_miss_addr", 64'(bus.miss_addr), 64'(32'h100));
    bus.miss_ready = 1'b1;
    tick();
    bus.miss_ready = 1'b0;
    check("sq_state_wait", 64'(dbg_state), 64'(LB_WAIT));
    bus.invalidate = 1'b1;
    tick();
    bus.invalidate = 1'b0;
    check("sq_state_idle", 64'(dbg_state), 64'(LB_IDLE));
    lookup(32'h000, 1'b0);
    lookup(32'h020, 1'b0);
    lookup(32'h040, 1'b0);
    lookup(32'h080, 1'b0);
    bus.req_valid = 1'b0;
    fill(32'h100, 32'hE010_0000);
    lookup(32'h100, 1'b0);
    bus.req_valid = 1'b0;
    fill(32'h200, 32'hE020_0000);
    lookup(32'h200, 1'b1);
    lookup(32'h21C, 1'b1);
    bus.req_valid = 1'b0;

    // invalidate wins over a same-cycle fill
    drive_fill(32'h300, 32'hF030_0000);
    bus.invalidate = 1'b1;
    tick();
    bus.fill_valid = 1'b0;
    bus.invalidate = 1'b0;
    lookup(32'h200, 1'b0);
    lookup(32'h300, 1'b0);

    // asynchronous reset in REQ
    lookup(32'h040, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    check("pre_rst_miss_valid", 64'(bus.miss_valid), 64'(1));
    rst = 1'b0;
    #1;
    check("async_rst_miss_valid", 64'(bus.miss_valid), 64'(0));
    check("async_rst_miss_addr", 64'(bus.miss_addr), 64'(0));
    check("async_rst_state", 64'(dbg_state), 64'(LB_IDLE));
    tick();
    rst = 1'b1;
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
